// File: rtl/avg_filter_pkg.sv
// Shared sizing helpers and rounding-mode constants for the multi-channel
// moving-average filter.
package avg_filter_pkg;

  localparam bit ROUND_FLOOR   = 1'b0;
  localparam bit ROUND_HALF_UP = 1'b1;

  function automatic int acc_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/avg_delay_line.sv
// Per-channel circular sample buffer. It exposes the oldest tap, which is the
// one the next push overwrites, and reports whether a push would fill the window.
module avg_delay_line #(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] oldest,
  output logic              full_after_push
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int PTR_W  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int FILL_W = LOG2_DEPTH + 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [FILL_W-1:0] fill;

  // Empty taps must read as zero so that the output ramps up before priming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr  <= '0;
      fill <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr  <= '0;
      fill <= '0;
    end else if (push) begin
      mem[ptr] <= data_in;
      ptr      <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
      if (fill != FULL) fill <= fill + 1'b1;
    end
  end

  assign oldest          = mem[ptr];
  assign full_after_push = (fill >= FULL - 1'b1);

endmodule

// File: rtl/moving_average_filter_mc.sv
// Multi-channel TDM boxcar moving-average filter. It keeps a running sum per
// channel, and each accepted sample produces one registered output a cycle later.
module moving_average_filter_mc
  import avg_filter_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int NUM_CH     = 2,
  parameter bit SIGNED     = 1'b0,
  parameter bit ROUND      = ROUND_FLOOR
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_ce,
  input  logic [ch_idx_w(NUM_CH)-1:0]   i_ch,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          i_clear,
  output logic [DATA_W-1:0]             data_out,
  output logic                          o_ce,
  output logic [ch_idx_w(NUM_CH)-1:0]   o_ch,
  output logic                          o_primed
);

  localparam int CH_W   = ch_idx_w(NUM_CH);
  localparam int ACC_W  = acc_width(DATA_W, LOG2_DEPTH);
  localparam int RND_SH = (LOG2_DEPTH > 0) ? LOG2_DEPTH - 1 : 0;
  localparam logic [ACC_W-1:0] RND =
    (ROUND == ROUND_HALF_UP && LOG2_DEPTH > 0) ? (ACC_W'(1) << RND_SH) : '0;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] x);
    if (SIGNED) return ACC_W'($signed(x));
    else        return ACC_W'(x);
  endfunction

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] full_after;
  logic [DATA_W-1:0] oldest [NUM_CH];
  logic [ACC_W-1:0]  sum    [NUM_CH];

  logic              accept;
  logic [ACC_W-1:0]  sum_sel;
  logic [DATA_W-1:0] oldest_sel;
  logic              full_sel;
  logic [ACC_W-1:0]  new_sum;
  logic [ACC_W-1:0]  rounded;
  logic [DATA_W-1:0] mean;

  assign accept = i_ce && !i_clear && ({1'b0, i_ch} < NUM_CH_L);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = accept && (i_ch == CH_W'(c));

    avg_delay_line #(
      .DATA_W    (DATA_W),
      .LOG2_DEPTH(LOG2_DEPTH)
    ) u_line (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (i_clear),
      .push           (push[c]),
      .data_in        (data_in),
      .oldest         (oldest[c]),
      .full_after_push(full_after[c])
    );
  end

  always_comb begin
    sum_sel    = '0;
    oldest_sel = '0;
    full_sel   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_ch == CH_W'(c)) begin
        sum_sel    = sum[c];
        oldest_sel = oldest[c];
        full_sel   = full_after[c];
      end
    end
    new_sum = sum_sel + ext(data_in) - ext(oldest_sel);
    rounded = new_sum + RND;
    mean    = SIGNED ? DATA_W'($signed(rounded) >>> LOG2_DEPTH)
                     : DATA_W'(rounded >> LOG2_DEPTH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) sum[c] <= '0;
    end else if (i_clear) begin
      for (int c = 0; c < NUM_CH; c++) sum[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (push[c]) sum[c] <= new_sum;
    end
  end

  // Output fields only move on an accepted sample; otherwise they hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      o_ce     <= 1'b0;
      o_ch     <= '0;
      o_primed <= 1'b0;
    end else begin
      o_ce <= accept;
      if (accept) begin
        data_out <= mean;
        o_ch     <= i_ch;
        o_primed <= full_sel;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_filter_mc.sv
// Self-checking bench: four filter variants share one stimulus stream and are
// compared every cycle against a queue-based window-mean model plus literal vectors.
module tb_moving_average_filter_mc;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_ce = 1'b0;
  logic       i_clear = 1'b0;
  logic [1:0] ch = 2'd0;
  logic [7:0] din = 8'd0;

  logic [7:0] dout  [4];
  logic       oce   [4];
  logic       oprim [4];
  logic       och_b [3];
  logic [1:0] och3;

  int n_checks = 0;
  int n_fail   = 0;

  // Variant table: 0 unsigned floor, 1 signed floor, 2 signed round, 3 three channels.
  int p_signed [4] = '{0, 1, 1, 0};
  int p_round  [4] = '{0, 0, 1, 0};
  int p_nch    [4] = '{2, 2, 2, 3};
  int p_chmask [4] = '{1, 1, 1, 3};

  always #5 clk = ~clk;

  moving_average_filter_mc #(.DATA_W(8), .LOG2_DEPTH(2), .NUM_CH(2), .SIGNED(0), .ROUND(0)) u0 (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_ch(ch[0]), .data_in(din), .i_clear(i_clear),
    .data_out(dout[0]), .o_ce(oce[0]), .o_ch(och_b[0]), .o_primed(oprim[0]));
  moving_average_filter_mc #(.DATA_W(8), .LOG2_DEPTH(2), .NUM_CH(2), .SIGNED(1), .ROUND(0)) u1 (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_ch(ch[0]), .data_in(din), .i_clear(i_clear),
    .data_out(dout[1]), .o_ce(oce[1]), .o_ch(och_b[1]), .o_primed(oprim[1]));
  moving_average_filter_mc #(.DATA_W(8), .LOG2_DEPTH(2), .NUM_CH(2), .SIGNED(1), .ROUND(1)) u2 (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_ch(ch[0]), .data_in(din), .i_clear(i_clear),
    .data_out(dout[2]), .o_ce(oce[2]), .o_ch(och_b[2]), .o_primed(oprim[2]));
  moving_average_filter_mc #(.DATA_W(8), .LOG2_DEPTH(2), .NUM_CH(3), .SIGNED(0), .ROUND(0)) u3 (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_ch(ch), .data_in(din), .i_clear(i_clear),
    .data_out(dout[3]), .o_ce(oce[3]), .o_ch(och3), .o_primed(oprim[3]));

  // Reference model: last four accepted samples per channel, as true integers.
  int q [4][3][$];
  int exp_data   [4] = '{0, 0, 0, 0};
  int exp_ch     [4] = '{0, 0, 0, 0};
  int exp_ce     [4] = '{0, 0, 0, 0};
  int exp_primed [4] = '{0, 0, 0, 0};

  function automatic int floor_div4(input int s);
    int r;
    r = s / 4;
    if ((s % 4 != 0) && (s < 0)) r = r - 1;
    return r;
  endfunction

  function automatic int as_value(input int k, input logic [7:0] v);
    if (p_signed[k] != 0) return int'($signed(v));
    return int'(v);
  endfunction

  task automatic model_flush(input int k);
    for (int c = 0; c < 3; c++) q[k][c].delete();
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        model_flush(k);
        exp_data[k] = 0; exp_ch[k] = 0; exp_ce[k] = 0; exp_primed[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        int s;
        c = int'(ch) & p_chmask[k];
        exp_ce[k] = (i_ce && !i_clear && c < p_nch[k]) ? 1 : 0;
        if (i_clear) model_flush(k);
        if (exp_ce[k] != 0) begin
          q[k][c].push_back(as_value(k, din));
          if (q[k][c].size() > 4) void'(q[k][c].pop_front());
          s = 0;
          foreach (q[k][c][i]) s += q[k][c][i];
          if (p_round[k] != 0) s += 2;
          exp_data[k]   = floor_div4(s) & 255;
          exp_ch[k]     = c;
          exp_primed[k] = (q[k][c].size() == 4) ? 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int act_ch(input int k);
    if (k < 3) return int'(och_b[k]);
    return int'(och3);
  endfunction

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("model_oce[%0d]", k), int'(oce[k]), exp_ce[k]);
      chk($sformatf("model_data[%0d]", k), int'(dout[k]), exp_data[k]);
      chk($sformatf("model_ch[%0d]", k), act_ch(k), exp_ch[k]);
      chk($sformatf("model_primed[%0d]", k), int'(oprim[k]), exp_primed[k]);
    end
  end

  task automatic applyStimulus(input bit ce, input int c, input int d, input bit clr);
    @(negedge clk);
    i_ce = ce; ch = 2'(c); din = 8'(d); i_clear = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int k, input bit ce, input int c,
                             input int d, input bit prim);
    chk({name, "_oce"}, int'(oce[k]), int'(ce));
    if (ce) begin
      chk({name, "_data"}, int'(dout[k]), d & 255);
      chk({name, "_ch"}, act_ch(k), c);
      chk({name, "_primed"}, int'(oprim[k]), int'(prim));
    end
  endtask

  int t2_in   [5] = '{4, 8, 12, 16, 20};
  int t2_out  [5] = '{1, 3, 6, 10, 14};
  int t4_out  [4] = '{63, 127, 191, 255};
  int t5_fl   [4] = '{-1, -2, -3, -3};
  int t5_rd   [4] = '{-1, -1, -2, -3};

  initial begin
    // Reset held while the inputs toggle randomly.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 255)), 1'b0);
      tick();
      chk("reset_oce", int'(oce[0]), 0);
      chk("reset_data", int'(dout[0]), 0);
      chk("reset_primed", int'(oprim[0]), 0);
    end
    @(negedge clk);
    reset_n = 1'b1; i_ce = 1'b0;

    // Single-channel ramp and priming.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 0, t2_in[i], 1'b0);
      tick();
      checkOutput("ramp", 0, 1'b1, 0, t2_out[i], i >= 3);
    end
    applyStimulus(1'b0, 0, 99, 1'b0);
    tick();
    checkOutput("idle", 0, 1'b0, 0, 0, 1'b0);
    chk("idle_hold_data", int'(dout[0]), 14);

    // Interleaved channels.
    applyStimulus(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 0, 100, 1'b0);
      tick();
      checkOutput("alt_ch0", 0, 1'b1, 0, 25 * (i + 1), i == 3);
      applyStimulus(1'b1, 1, 200, 1'b0);
      tick();
      checkOutput("alt_ch1", 0, 1'b1, 1, 50 * (i + 1), i == 3);
    end

    // Full-scale input without wrap.
    applyStimulus(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1, 255, 1'b0);
      tick();
      checkOutput("max_ch1", 0, 1'b1, 1, t4_out[i], i == 3);
    end

    // Signed -3 stream, floor and half-up variants.
    applyStimulus(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 0, 253, 1'b0);
      tick();
      checkOutput("signed_floor", 1, 1'b1, 0, t5_fl[i], i == 3);
      checkOutput("signed_round", 2, 1'b1, 0, t5_rd[i], i == 3);
    end

    // Clear beats a simultaneous sample; outputs hold.
    applyStimulus(1'b1, 0, 50, 1'b1);
    tick();
    checkOutput("clear_drop", 0, 1'b0, 0, 0, 1'b0);
    chk("clear_hold_data", int'(dout[0]), 253);
    applyStimulus(1'b1, 0, 8, 1'b0);
    tick();
    checkOutput("after_clear", 0, 1'b1, 0, 2, 1'b0);
    checkOutput("after_clear3", 3, 1'b1, 0, 2, 1'b0);

    // Out-of-range channel on the three-channel variant.
    applyStimulus(1'b1, 3, 40, 1'b0);
    tick();
    checkOutput("bad_ch", 3, 1'b0, 0, 0, 1'b0);
    chk("bad_ch_hold", int'(dout[3]), 2);

    // Reset asserted mid-stream clears outputs immediately.
    applyStimulus(1'b1, 1, 77, 1'b0);
    applyStimulus(1'b1, 0, 90, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_data", int'(dout[0]), 0);
    chk("async_rst_oce", int'(oce[0]), 0);
    chk("async_rst_ch", act_ch(0), 0);
    chk("async_rst_primed", int'(oprim[0]), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0);
    tick();
    checkOutput("post_rst_quiet", 0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1, 60, 1'b0);
    tick();
    checkOutput("post_rst_fresh", 0, 1'b1, 1, 15, 1'b0);

    applyStimulus(1'b0, 0, 0, 1'b0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
